// File: rtl/cplx_bank_pkg.sv
// Shared definitions for the four-bank complex-sample peak search.
//   NUM_BANKS / BANK_SEL_W : bank count and bank-select width
//   state_e                : sequencer states
//   mag_width()            : width of a per-sample magnitude for a given component width
package cplx_bank_pkg;

    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned BANK_SEL_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SCAN,
        FLUSH,
        DONE
    } state_e;

    // Squared magnitude of two WIDTH-bit components needs 2*WIDTH bits, unsigned.
    function automatic int unsigned mag_width(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/cplx_mag.sv
// Registered magnitude of one complex sample.
//   clk, rst : clock, synchronous active-high reset
//   re_i     : real part, two's complement
//   im_i     : imaginary part, two's complement
//   mag_o    : re*re + im*im, unsigned; one cycle after re_i/im_i
// Build option CPLX_MAG_L1_EN: mag_o = |re| + |im| zero-extended, no multipliers.
module cplx_mag
    import cplx_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             re_i,
    input  logic [WIDTH-1:0]             im_i,
    output logic [mag_width(WIDTH)-1:0]  mag_o
);

    localparam int unsigned MagW = mag_width(WIDTH);

    logic [MagW-1:0] mag_d, mag_q;

`ifdef CPLX_MAG_L1_EN
    // One extra bit so |-2**(WIDTH-1)| does not wrap.
    logic signed [WIDTH:0] re_x, im_x;
    logic        [WIDTH:0] re_abs, im_abs;
    logic      [WIDTH+1:0] l1_sum;

    always_comb begin
        re_x   = {re_i[WIDTH-1], re_i};
        im_x   = {im_i[WIDTH-1], im_i};
        re_abs = re_x[WIDTH] ? -re_x : re_x;
        im_abs = im_x[WIDTH] ? -im_x : im_x;
        l1_sum = {1'b0, re_abs} + {1'b0, im_abs};
        mag_d  = MagW'(l1_sum);
    end
`else
    // Sign-extend to the full product width; each square is non-negative and
    // the sum of two squares fits in MagW bits when read as unsigned.
    logic signed [MagW-1:0] re_x, im_x, re_sq, im_sq;

    always_comb begin
        re_x  = {{(MagW - WIDTH){re_i[WIDTH-1]}}, re_i};
        im_x  = {{(MagW - WIDTH){im_i[WIDTH-1]}}, im_i};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        mag_d = re_sq + im_sq;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign mag_o = mag_q;

endmodule

// File: rtl/cplx_bank_max_ctrl.sv
// Fill/scan sequencer for four dual-port complex-sample RAM banks; reports the
// index and magnitude of the largest sample.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begins a pass when idle
//   in_valid/in_ready     : sample stream handshake, in_real/in_imag payload
//   we_*/din_*/w_addr     : bank write side (sample n -> bank n%4, addr n/4)
//   r_addr, dout_*        : bank read side, 1-cycle read latency
//   busy, done            : status, done pulses with max_idx/max_mag valid
// Build option CPLX_MAG_L1_EN selects |re|+|im| inside cplx_mag.
module cplx_bank_max_ctrl
    import cplx_bank_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_real,
    input  logic [WIDTH-1:0]              in_imag,
    output logic [NUM_BANKS-1:0]          we_real,
    output logic [NUM_BANKS-1:0]          we_imag,
    output logic [NUM_BANKS*WIDTH-1:0]    din_real,
    output logic [NUM_BANKS*WIDTH-1:0]    din_imag,
    output logic [ADDR_WIDTH-1:0]         w_addr,
    output logic [ADDR_WIDTH-1:0]         r_addr,
    input  logic [NUM_BANKS*WIDTH-1:0]    dout_real,
    input  logic [NUM_BANKS*WIDTH-1:0]    dout_imag,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH+1:0]         max_idx,
    output logic [2*WIDTH-1:0]            max_mag
);

    localparam int unsigned CntW = ADDR_WIDTH + BANK_SEL_W;
    localparam int unsigned MagW = mag_width(WIDTH);
    localparam logic [CntW-1:0] FillLast = CntW'(NUM_BANKS * DEPTH - 1);
    localparam logic [CntW-1:0] ScanLast = CntW'(DEPTH - 1);
    localparam logic [CntW-1:0] FlushLast = CntW'(1);

    state_e state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic scan_init, scan_v;

    // Read pipeline: rd_* aligns with dout, cap_* with the captured data,
    // mag_* with the registered magnitudes.
    logic rd_v_q, cap_v_q, mag_v_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, cap_addr_q, mag_addr_q;
    logic [NUM_BANKS*WIDTH-1:0] cap_re_q, cap_im_q;
    logic [MagW-1:0] mag [NUM_BANKS];

    logic [ADDR_WIDTH+1:0] max_idx_d, max_idx_q;
    logic [MagW-1:0] max_mag_d, max_mag_q;
    logic done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        we_real   = '0;
        we_imag   = '0;
        din_real  = '0;
        din_imag  = '0;
        w_addr    = '0;
        r_addr    = '0;
        scan_init = 1'b0;
        scan_v    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                din_real = {NUM_BANKS{in_real}};
                din_imag = {NUM_BANKS{in_imag}};
                w_addr   = cnt_q[CntW-1:BANK_SEL_W];
                if (in_valid) begin
                    we_real = NUM_BANKS'(1) << cnt_q[BANK_SEL_W-1:0];
                    we_imag = NUM_BANKS'(1) << cnt_q[BANK_SEL_W-1:0];
                    if (cnt_q == FillLast) begin
                        state_d   = SCAN;
                        cnt_d     = '0;
                        scan_init = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SCAN: begin
                scan_v = 1'b1;
                r_addr = cnt_q[ADDR_WIDTH-1:0];
                if (cnt_q == ScanLast) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == FlushLast) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_mag
        cplx_mag #(
            .WIDTH (WIDTH)
        ) u_mag (
            .clk   (clk),
            .rst   (rst),
            .re_i  (cap_re_q[g*WIDTH +: WIDTH]),
            .im_i  (cap_im_q[g*WIDTH +: WIDTH]),
            .mag_o (mag[g])
        );
    end

    // Bank 0 first and strict '>' so ties keep the lowest index; earlier
    // addresses already sit in the running max.
    always_comb begin
        max_mag_d = max_mag_q;
        max_idx_d = max_idx_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (mag[b] > max_mag_d) begin
                max_mag_d = mag[b];
                max_idx_d = {mag_addr_q, BANK_SEL_W'(b)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_v_q     <= 1'b0;
            cap_v_q    <= 1'b0;
            mag_v_q    <= 1'b0;
            rd_addr_q  <= '0;
            cap_addr_q <= '0;
            mag_addr_q <= '0;
            cap_re_q   <= '0;
            cap_im_q   <= '0;
            max_idx_q  <= '0;
            max_mag_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_v_q     <= scan_v;
            cap_v_q    <= rd_v_q;
            mag_v_q    <= cap_v_q;
            rd_addr_q  <= r_addr;
            cap_addr_q <= rd_addr_q;
            mag_addr_q <= cap_addr_q;
            cap_re_q   <= dout_real;
            cap_im_q   <= dout_imag;
            if (scan_init) begin
                max_idx_q <= '0;
                max_mag_q <= '0;
            end else if (mag_v_q) begin
                max_idx_q <= max_idx_d;
                max_mag_q <= max_mag_d;
            end
            // The last running-max update lands on the DONE cycle, so the
            // pulse follows one cycle later.
            done_q     <= (state_q == DONE);
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign max_idx = max_idx_q;
    assign max_mag = max_mag_q;

endmodule

// File: tb/tb_cplx_bank_max_ctrl.sv
// Self-checking bench for cplx_bank_max_ctrl with a behavioural four-bank RAM.
module tb_cplx_bank_max_ctrl;

    localparam int W  = 8;
    localparam int AW = 3;
    localparam int D  = 8;
    localparam int N  = 4 * D;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready;
    logic [W-1:0] in_real, in_imag;
    logic [3:0] we_real, we_imag;
    logic [4*W-1:0] din_real, din_imag, dout_real, dout_imag;
    logic [AW-1:0] w_addr, r_addr;
    logic busy, done;
    logic [AW+1:0] max_idx;
    logic [2*W-1:0] max_mag;

    always #5 clk = ~clk;

    cplx_bank_max_ctrl #(
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .DEPTH      (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .we_real   (we_real),
        .we_imag   (we_imag),
        .din_real  (din_real),
        .din_imag  (din_imag),
        .w_addr    (w_addr),
        .r_addr    (r_addr),
        .dout_real (dout_real),
        .dout_imag (dout_imag),
        .busy      (busy),
        .done      (done),
        .max_idx   (max_idx),
        .max_mag   (max_mag)
    );

    // Behavioural RAM banks, 1-cycle read latency.
    logic [W-1:0] ram_re [4][D];
    logic [W-1:0] ram_im [4][D];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_real[b]) ram_re[b][w_addr] <= din_real[b*W +: W];
            if (we_imag[b]) ram_im[b][w_addr] <= din_imag[b*W +: W];
            dout_real[b*W +: W] <= ram_re[b][r_addr];
            dout_imag[b*W +: W] <= ram_im[b][r_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    int exp_idx_q[$], exp_mag_q[$], obs_idx_q[$], obs_mag_q[$];
    logic [W-1:0] smp_re [N];
    logic [W-1:0] smp_im [N];

    int wr_n, wr_bad, done_n, lat;
    logic busy_end;
    logic ab_busy, ab_done;
    logic [AW+1:0] ab_idx;
    logic [2*W-1:0] ab_mag;
    logic [3:0] ab_we;

    function automatic int model_mag(input logic [W-1:0] re, input logic [W-1:0] im);
        int r;
        int i;
        r = int'($signed(re));
        i = int'($signed(im));
`ifdef CPLX_MAG_L1_EN
        if (r < 0) r = -r;
        if (i < 0) i = -i;
        return r + i;
`else
        return r * r + i * i;
`endif
    endfunction

    // Entered and left at #1 after a rising edge. Pushes the expected result,
    // streams smp_*, then watches 40 cycles from the first SCAN cycle.
    task automatic drive_pass(input bit toggle_valid, input bit poke_start, input int abort_k);
        int best_m, best_i, m, n, cyc;
        bit v;
        best_m = 0;
        best_i = 0;
        for (int i = 0; i < N; i++) begin
            m = model_mag(smp_re[i], smp_im[i]);
            if (m > best_m) begin
                best_m = m;
                best_i = i;
            end
        end
        if (abort_k < 0) begin
            exp_idx_q.push_back(best_i);
            exp_mag_q.push_back(best_m);
        end
        wr_n = 0;
        wr_bad = 0;
        done_n = 0;
        lat = -1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < N && cyc < 200) begin
            v = toggle_valid ? (cyc % 2 == 0) : 1'b1;
            in_valid = v;
            in_real = smp_re[n];
            in_imag = smp_im[n];
            start = poke_start && (cyc == 3);
            @(negedge clk);
            if (we_real != 4'b0 || we_imag != 4'b0) wr_n++;
            if (v) begin
                if (!in_ready || we_real != (4'b0001 << (n % 4)) || we_imag != we_real ||
                    w_addr != AW'(n / 4) || din_real != {4{smp_re[n]}} ||
                    din_imag != {4{smp_im[n]}}) wr_bad++;
                n++;
            end else if (we_real != 4'b0 || we_imag != 4'b0) begin
                wr_bad++;
            end
            @(posedge clk);
            #1 cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            start = poke_start && (k == 2);
            if (k == abort_k) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                ab_busy = busy;
                ab_done = done;
                ab_idx = max_idx;
                ab_mag = max_mag;
                ab_we = we_real | we_imag;
                @(posedge clk);
                #1;
                break;
            end
            @(negedge clk);
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = k;
                    obs_idx_q.push_back(int'(max_idx));
                    obs_mag_q.push_back(int'(max_mag));
                end
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_real = '0;
        in_imag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (max_idx !== '0 || max_mag !== '0) begin
            errors++;
            $display("FAIL reset_max: idx=%0d mag=%0d, required 0 0", max_idx, max_mag);
        end
        checks++;
        if (we_real !== 4'b0 || we_imag !== 4'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_write: we=%b/%b ready=%b, required 0", we_real, we_imag,
                     in_ready);
        end
        checks++;
        if (w_addr !== '0 || r_addr !== '0 || din_real !== '0) begin
            errors++;
            $display("FAIL reset_addr: w=%0d r=%0d din=%h, required 0", w_addr, r_addr, din_real);
        end
        @(posedge clk);
        #1;
    endtask

    // Pops one scoreboard entry and compares it with the observed result.
    task automatic test_result(input string name);
        int e_i, e_m, o_i, o_m;
        e_i = exp_idx_q.pop_front();
        e_m = exp_mag_q.pop_front();
        o_i = -1;
        o_m = -1;
        if (obs_idx_q.size() > 0) begin
            o_i = obs_idx_q.pop_front();
            o_m = obs_mag_q.pop_front();
        end
        checks++;
        if (o_i !== e_i) begin
            errors++;
            $display("FAIL %s_idx: got %0d, required %0d", name, o_i, e_i);
        end
        checks++;
        if (o_m !== e_m) begin
            errors++;
            $display("FAIL %s_mag: got %0d, required %0d", name, o_m, e_m);
        end
        checks++;
        if (done_n != 1 || lat != D + 3) begin
            errors++;
            $display("FAIL %s_done: pulses=%0d latency=%0d, required 1 and %0d", name, done_n,
                     lat, D + 3);
        end
        checks++;
        if (wr_n != N || wr_bad != 0) begin
            errors++;
            $display("FAIL %s_writes: count=%0d bad=%0d, required %0d and 0", name, wr_n,
                     wr_bad, N);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) begin
            smp_re[i] = W'(i);
            smp_im[i] = '0;
        end
        drive_pass(1'b0, 1'b0, -1);
        test_result("ramp");
    endtask

    task automatic test_neg_corner();
        for (int i = 0; i < N; i++) begin
            smp_re[i] = (i == 13) ? 8'h80 : 8'h01;
            smp_im[i] = (i == 13) ? 8'h80 : 8'h01;
        end
        drive_pass(1'b0, 1'b0, -1);
        test_result("neg_corner");
    endtask

    task automatic test_tie();
        for (int i = 0; i < N; i++) begin
            smp_re[i] = (i == 5 || i == 22) ? 8'd3 : 8'd0;
            smp_im[i] = (i == 5 || i == 22) ? 8'd4 : 8'd0;
        end
        drive_pass(1'b0, 1'b0, -1);
        test_result("tie");
    endtask

    task automatic test_toggle_start();
        for (int i = 0; i < N; i++) begin
            smp_re[i] = W'($urandom_range(255));
            smp_im[i] = W'($urandom_range(255));
        end
        drive_pass(1'b1, 1'b1, -1);
        test_result("toggle");
        checks++;
        if (busy_end !== 1'b0) begin
            errors++;
            $display("FAIL toggle_restart: busy=%b after pass, required 0", busy_end);
        end
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < N; i++) begin
            smp_re[i] = W'(N - i);
            smp_im[i] = W'(i);
        end
        drive_pass(1'b0, 1'b0, 5);
        checks++;
        if (ab_busy !== 1'b0 || ab_done !== 1'b0 || ab_we !== 4'b0) begin
            errors++;
            $display("FAIL abort_status: busy=%b done=%b we=%b, required 0", ab_busy, ab_done,
                     ab_we);
        end
        checks++;
        if (ab_idx !== '0 || ab_mag !== '0) begin
            errors++;
            $display("FAIL abort_max: idx=%0d mag=%0d, required 0 0", ab_idx, ab_mag);
        end
        drive_pass(1'b0, 1'b0, -1);
        test_result("after_abort");
    endtask

    task automatic test_zeros();
        for (int i = 0; i < N; i++) begin
            smp_re[i] = '0;
            smp_im[i] = '0;
        end
        drive_pass(1'b0, 1'b0, -1);
        test_result("zeros");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_neg_corner();
        test_tie();
        test_toggle_start();
        test_reset_mid_scan();
        test_zeros();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cplx_bank_max_ctrl.md
Name: cplx_bank_max_ctrl

Overview:
Sequencer for the four-bank complex-sample RAM (four true-dual-port RAMs, each holding real on port a and imaginary on port b).
- Fill phase: accepts a stream of 4*DEPTH complex samples and writes them round-robin into the banks.
- Scan phase: reads every entry back, computes its magnitude and reports the index and magnitude of the largest sample.
- This is the peak-search front end of the V2V sorter.

Parameters:
- WIDTH, 8: bits per real/imag component, two's complement.
- ADDR_WIDTH, 3: RAM address width.
- DEPTH, 8: entries per bank. DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a fill+scan pass when idle.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts a sample.
- in_real  in  WIDTH  sample real part.
- in_imag  in  WIDTH  sample imaginary part.
- we_real  out  4  per-bank port-a write enable (bit k = bank k).
- we_imag  out  4  per-bank port-b write enable.
- din_real  out  4*WIDTH  per-bank real write data, bank k at [k*WIDTH +: WIDTH].
- din_imag  out  4*WIDTH  per-bank imaginary write data.
- w_addr  out  ADDR_WIDTH  write address, shared by all banks and both ports.
- r_addr  out  ADDR_WIDTH  read address, shared by all banks and both ports.
- dout_real  in  4*WIDTH  per-bank real read data.
- dout_imag  in  4*WIDTH  per-bank imaginary read data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle result-valid pulse.
- max_idx  out  ADDR_WIDTH+2  winning sample index.
- max_mag  out  2*WIDTH  winning magnitude.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; RAM contents are not touched.
- States: IDLE -> FILL -> SCAN -> FLUSH -> DONE -> IDLE.
- IDLE
  - in_ready=0.
  - start=1 moves to FILL.
  - in_valid is ignored.
- FILL
  - in_ready=1.
  - Each cycle with in_valid=1 accepts sample n (n = 0 .. 4*DEPTH-1).
  - Same cycle: bank = n mod 4, w_addr = n/4, we_real[bank]=we_imag[bank]=1. All other we bits are 0.
  - din_real/din_imag carry the sample in every bank slot.
  - in_valid=0 means no write and no count.
  - After accepting n = 4*DEPTH-1, the next state is SCAN.
- SCAN (DEPTH cycles)
  - r_addr = 0 .. DEPTH-1, one per cycle.
  - RAM read latency is 1 cycle: dout is valid the cycle after r_addr is presented.
- Pipeline
  - Stage 1: dout captured as RAM output.
  - Stage 2: per-bank magnitude registered, mag = re*re + im*im, signed multiply, unsigned 2*WIDTH-bit result. The maximum 2*(2**(WIDTH-1))**2 fits.
  - Stage 3: running max updated.
- FLUSH: 2 cycles draining the pipeline, then DONE.
- Compare rules
  - Candidate index = addr*4 + bank.
  - Within one address, banks are compared in order 0..3.
  - Replace only on strict greater-than, so ties keep the lowest index.
  - The running max initialises to mag 0, idx 0 at SCAN entry.
- DONE
  - done=1 for exactly 1 cycle with max_idx/max_mag valid; then IDLE.
  - max_idx/max_mag hold until the next SCAN entry.
- Latency: done is asserted DEPTH+3 cycles after the first SCAN cycle.
- start while busy: ignored.
- rst mid-pass: the next edge returns to IDLE with all outputs 0. A partially written RAM is left as is.
- All-zero data: max_idx=0, max_mag=0.

Optional Feature:
- CPLX_MAG_L1_EN defined: stage-2 magnitude is |re|+|im|, zero-extended to 2*WIDTH. No multipliers are inferred. |-2**(WIDTH-1)| is handled in WIDTH+1 bits.
- Undefined: squared magnitude as above.
- Pipeline depth and latency are identical in both builds.

Decomposition:
- Package cplx_bank_pkg holds:
  - NUM_BANKS=4 and BANK_SEL_W=2.
  - State enum type (IDLE, FILL, SCAN, FLUSH, DONE).
  - Magnitude width function.
- Sub-module cplx_mag: one per bank, registered stage-2 magnitude including the CPLX_MAG_L1_EN switch; instantiated 4 times.

Test Plan:
- Reset, then start; stream 32 samples with real=n, imag=0 (WIDTH=8, DEPTH=8) and continuous valid -> writes to bank n%4 at addr n/4; done 11 cycles after SCAN entry; max_idx=31, max_mag=961.
- Sample 13 = (-128,-128), all others (1,1) -> max_idx=13, max_mag=32768. With CPLX_MAG_L1_EN: max_mag=256.
- Samples 5 and 22 both (3,4), all others 0 -> max_idx=5, max_mag=25.
- in_valid toggled 1,0,1,0 during FILL; start pulsed while busy -> only valid cycles write; no restart; exactly 32 writes; one done.
- rst asserted during SCAN -> next cycle busy=0, done=0, max_idx=0, max_mag=0, all we=0; a fresh start completes normally.
- All samples 0 -> done with max_idx=0, max_mag=0.
